// File: rtl/processing_element.sv
// processing_element: one SIMD lane holding two operand rows (A, B) and a serial
// dot-product accumulator stepped element by element by the array controller.
module processing_element #(
  parameter  int N  = 16,
  localparam int PW = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [N-1:0][31:0]   DATAIN,
  input  logic                 MAC_CTRL,
  input  logic                 RST_MUL,
  input  logic                 INC_PC,
  input  logic                 MAT_MUX,
  input  logic                 WRITE_MAT,
  output logic [PW-1:0]        PC_Counter,
  output logic [31:0]          DATAOUT
);

  logic [N-1:0][31:0] mat_a_q, mat_a_d;
  logic [N-1:0][31:0] mat_b_q, mat_b_d;
  logic [31:0]        acc_q, acc_d;
  logic [PW-1:0]      pc_q, pc_d;
  logic [31:0]        prod_s;

  // Next-state: row loads are independent of the MAC path, which reads the pre-write rows.
  always_comb begin
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    prod_s  = mat_a_q[pc_q] * mat_b_q[pc_q];

    if (WRITE_MAT) begin
      if (MAT_MUX) begin
        mat_b_d = DATAIN;
      end else begin
        mat_a_d = DATAIN;
      end
    end else begin
      mat_a_d = mat_a_q;
    end

    if (RST_MUL) begin
      acc_d = 32'd0;
      pc_d  = {PW{1'b0}};
    end else begin
      if (MAC_CTRL) begin
        acc_d = acc_q + prod_s;
      end else begin
        acc_d = acc_q;
      end
      if (INC_PC) begin
        pc_d = pc_q + PW'(1);
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State registers with synchronous active-low reset clearing rows, accumulator and PC.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      mat_a_q <= '{default: 32'd0};
      mat_b_q <= '{default: 32'd0};
      acc_q   <= 32'd0;
      pc_q    <= {PW{1'b0}};
    end else begin
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
    end
  end

  assign DATAOUT    = acc_q;
  assign PC_Counter = pc_q;

endmodule

// File: tb/tb_processing_element.sv
// Directed bench for processing_element: a behavioural lane model feeds a scoreboard
// queue each cycle, plus constant checks of the known dot-product results.
module tb_processing_element;

  localparam int N = 16;

  logic               clk;
  logic               rstn;
  logic [N-1:0][31:0] datain;
  logic               mac_ctrl, rst_mul, inc_pc, mat_mux, write_mat;
  logic [3:0]         pc_counter;
  logic [31:0]        dataout;

  typedef struct packed {
    logic [31:0] acc;
    logic [3:0]  pc;
  } exp_t;

  exp_t sb_q[$];

  logic [N-1:0][31:0] m_a, m_b;
  logic [31:0]        m_acc;
  logic [3:0]         m_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N-1:0][31:0] din_desc, din_zero, din_x, din_big, din_a3, din_b5, din_16;

  processing_element #(.N(N)) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .DATAIN    (datain),
    .MAC_CTRL  (mac_ctrl),
    .RST_MUL   (rst_mul),
    .INC_PC    (inc_pc),
    .MAT_MUX   (mat_mux),
    .WRITE_MAT (write_mat),
    .PC_Counter(pc_counter),
    .DATAOUT   (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive one cycle, advance the model, push its prediction, then pop and compare after the edge.
  task automatic step(input string tag, input logic rn, input logic wm, input logic mm,
                      input logic mac, input logic inc, input logic rmul,
                      input logic [N-1:0][31:0] din);
    logic [63:0] full;
    exp_t        e;
    rstn = rn; write_mat = wm; mat_mux = mm;
    mac_ctrl = mac; inc_pc = inc; rst_mul = rmul; datain = din;
    if (!rn) begin
      m_a = '0; m_b = '0; m_acc = 32'd0; m_pc = 4'd0;
    end else begin
      full = 64'(m_a[m_pc]) * 64'(m_b[m_pc]);
      if (rmul) begin
        m_acc = 32'd0; m_pc = 4'd0;
      end else begin
        if (mac) m_acc = m_acc + full[31:0];
        if (inc) m_pc = 4'((int'(m_pc) + 1) % N);
      end
      if (wm) begin
        if (mm) m_b = din;
        else    m_a = din;
      end
    end
    sb_q.push_back('{acc: m_acc, pc: m_pc});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_acc"}, dataout, e.acc);
    chk({tag, "_pc"}, 32'(pc_counter), 32'(e.pc));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      din_desc[i] = 32'(16 - i);
      din_zero[i] = 32'd0;
      din_x[i]    = 32'hxxxx_xxxx;
      din_big[i]  = 32'd0;
      din_a3[i]   = 32'd0;
      din_b5[i]   = 32'd0;
      din_16[i]   = 32'd16;
    end
    din_big[0] = 32'h0001_0000;
    din_a3[0]  = 32'd3;
    din_b5[0]  = 32'd5;

    rstn = 1'b0; write_mat = 1'b0; mat_mux = 1'b0;
    mac_ctrl = 1'b0; inc_pc = 1'b0; rst_mul = 1'b0; datain = din_zero;
    m_a = '0; m_b = '0; m_acc = 32'd0; m_pc = 4'd0;

    // 1: reset (with controls asserted, reset must win), then MAC on zeroed rows
    step("rst0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, din_desc);
    step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, din_zero);
    chk("t1_rst_dout", dataout, 32'd0);
    chk("t1_rst_pc", 32'(pc_counter), 32'd0);
    step("mac0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, din_zero);
    chk("t1_mac_zero", dataout, 32'd0);

    // 2: full dot product of 16..1 with itself
    step("ldA", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, din_desc);
    step("ldB", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din_desc);
    for (int i = 0; i < N; i++) step("dot", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, din_zero);
    chk("t2_dot", dataout, 32'd1496);
    chk("t2_pc", 32'(pc_counter), 32'd0);
    for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, din_x);
    chk("t2_hold", dataout, 32'd1496);

    // 3: PC walks and wraps on INC_PC alone
    for (int i = 0; i < 17; i++) begin
      step("inc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, din_zero);
      chk("t3_pc_seq", 32'(pc_counter), 32'((i + 1) % N));
    end
    chk("t3_dout_kept", dataout, 32'd1496);

    // 4: product wraps modulo 2^32; then 3*5 accumulated twice
    step("ldAbig", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, din_big);
    step("ldBbig", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din_big);
    step("rmul4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, din_zero);
    step("wrap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, din_zero);
    chk("t4_wrap1", dataout, 32'd0);
    step("wrap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, din_zero);
    chk("t4_wrap2", dataout, 32'd0);
    step("ldA3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, din_a3);
    step("ldB5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din_b5);
    step("mac35", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, din_zero);
    chk("t4_mac15", dataout, 32'd15);
    step("mac35", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, din_zero);
    chk("t4_mac30", dataout, 32'd30);
    chk("t4_pc_still", 32'(pc_counter), 32'd0);

    // 5: RST_MUL mid-run beats INC/MAC and leaves rows intact
    step("ldA5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, din_desc);
    step("ldB5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din_desc);
    step("rmul5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, din_zero);
    for (int i = 0; i < 7; i++) step("part", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, din_zero);
    chk("t5_pc7", 32'(pc_counter), 32'd7);
    step("abort", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, din_zero);
    chk("t5_abort_dout", dataout, 32'd0);
    chk("t5_abort_pc", 32'(pc_counter), 32'd0);
    for (int i = 0; i < N; i++) step("redo", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, din_zero);
    chk("t5_redo", dataout, 32'd1496);

    // 6: same-cycle write of B and MAC uses old B; later MACs see zeros
    step("ldA16", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, din_16);
    step("ldB16", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din_16);
    step("rmul6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, din_zero);
    step("wrmac", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, din_zero);
    chk("t6_old_row", dataout, 32'd256);
    chk("t6_pc1", 32'(pc_counter), 32'd1);
    for (int i = 0; i < 3; i++) step("bzero", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, din_zero);
    chk("t6_new_row", dataout, 32'd256);

    // Final reset clears everything
    step("rstend", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, din_zero);
    chk("end_rst_dout", dataout, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
